// File: rtl/drac_pkg.sv
// Shared types for the branch execution pipe: opcode encoding, pipeline
// control/flag payloads and the misaligned-target exception cause.
package drac_pkg;

    typedef enum logic [2:0] {
        BR_EQ   = 3'd0,
        BR_NE   = 3'd1,
        BR_LT   = 3'd2,
        BR_GE   = 3'd3,
        BR_LTU  = 3'd4,
        BR_GEU  = 3'd5,
        BR_JAL  = 3'd6,
        BR_JALR = 3'd7
    } branch_op_t;

    // Exception cause code for instruction-address-misaligned.
    localparam logic [63:0] INSTR_ADDR_MISALIGNED = 64'd0;

    // Width-independent control carried through S1.
    typedef struct packed {
        branch_op_t op;
        logic       is_rvc;
        logic       pred_taken;
    } s1_ctrl_t;

    // Resolved flags registered in S2.
    typedef struct packed {
        logic taken;
        logic mispredict;
        logic ex_valid;
    } s2_flags_t;

endpackage

// File: rtl/branch_cond_calc.sv
// Combinational branch resolution: direction, target, fall-through link
// and target alignment check.
module branch_cond_calc
    import drac_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned RVC_EN = 0
) (
    input  branch_op_t        op,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic              is_rvc,
    output logic [XLEN-1:0]   target_c,
    output logic [XLEN-1:0]   link_c,
    output logic              taken_c,
    output logic              misaligned_c
);

    logic            equal;
    logic            lt;
    logic            ltu;
    logic [XLEN-1:0] pc_sum;
    logic [XLEN-1:0] reg_sum;

    always_comb begin
        equal   = (rs1 == rs2);
        lt      = ($signed(rs1) < $signed(rs2));
        ltu     = (rs1 < rs2);
        pc_sum  = pc + imm;
        reg_sum = rs1 + imm;

        taken_c  = 1'b0;
        target_c = pc_sum;
        case (op)
            BR_EQ:   taken_c = equal;
            BR_NE:   taken_c = !equal;
            BR_LT:   taken_c = lt;
            BR_GE:   taken_c = !lt;
            BR_LTU:  taken_c = ltu;
            BR_GEU:  taken_c = !ltu;
            BR_JAL: begin
                taken_c  = 1'b1;
                target_c = {pc_sum[XLEN-1:1], 1'b0};
            end
            BR_JALR: begin
                taken_c  = 1'b1;
                target_c = {reg_sum[XLEN-1:1], 1'b0};
            end
            default: taken_c = 1'b0;
        endcase

        link_c       = pc + (((RVC_EN != 0) && is_rvc) ? XLEN'(2) : XLEN'(4));
        // Jump targets have bit0 cleared, so only branches can fail the RVC check.
        misaligned_c = (RVC_EN != 0) ? target_c[0] : target_c[1];
    end

endmodule

// File: rtl/branch_exec_pipe.sv
// Two-stage branch execution unit: S1 captures the issued entry, S2 holds
// the resolved result, with valid/ready flow control, flush and statistics.
module branch_exec_pipe
    import drac_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned RVC_EN = 0,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  branch_op_t        op_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic              is_rvc_i,
    input  logic              pred_taken_i,
    input  logic [XLEN-1:0]   pred_target_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              taken_o,
    output logic [XLEN-1:0]   target_o,
    output logic [XLEN-1:0]   link_o,
    output logic              mispredict_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_origin_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispredict_cnt_o
);

    typedef struct packed {
        s1_ctrl_t         ctrl;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [XLEN-1:0]  pred_target;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        s2_flags_t        flags;
        logic [XLEN-1:0]  target;
        logic [XLEN-1:0]  link;
        logic [XLEN-1:0]  redirect;
        logic [TAG_W-1:0] tag;
    } s2_t;

    logic            s1_v;
    logic            s2_v;
    s1_t             s1_q;
    s2_t             s2_q;
    s2_t             s2_d;
    s1_t             s1_d;
    logic            s1_adv;
    logic            s2_adv;
    logic            accept;
    logic            out_xfer;

    logic [XLEN-1:0] calc_target;
    logic [XLEN-1:0] calc_link;
    logic            calc_taken;
    logic            calc_misaligned;
    logic [XLEN-1:0] actual_pc;
    logic [XLEN-1:0] pred_pc;
    logic            ex_hit;

    // Flow control: S2 drains on ready_i, S1 moves whenever S2 has room.
    always_comb begin
        s2_adv   = !s2_v || ready_i;
        s1_adv   = s2_adv || !s1_v;
        accept   = valid_i && s1_adv;
        out_xfer = s2_v && ready_i;
    end

    assign ready_o = s1_adv;

    always_comb begin
        s1_d                  = '0;
        s1_d.ctrl.op          = op_i;
        s1_d.ctrl.is_rvc      = is_rvc_i;
        s1_d.ctrl.pred_taken  = pred_taken_i;
        s1_d.pc               = pc_i;
        s1_d.imm              = imm_i;
        s1_d.rs1              = rs1_i;
        s1_d.rs2              = rs2_i;
        s1_d.pred_target      = pred_target_i;
        s1_d.tag              = tag_i;
    end

    branch_cond_calc #(
        .XLEN   (XLEN),
        .RVC_EN (RVC_EN)
    ) u_calc (
        .op           (s1_q.ctrl.op),
        .pc           (s1_q.pc),
        .imm          (s1_q.imm),
        .rs1          (s1_q.rs1),
        .rs2          (s1_q.rs2),
        .is_rvc       (s1_q.ctrl.is_rvc),
        .target_c     (calc_target),
        .link_c       (calc_link),
        .taken_c      (calc_taken),
        .misaligned_c (calc_misaligned)
    );

    // Next-PC comparison; an exception suppresses the redirect-as-mispredict.
    always_comb begin
        ex_hit    = calc_taken && calc_misaligned;
        actual_pc = calc_taken ? calc_target : calc_link;
        pred_pc   = s1_q.ctrl.pred_taken ? s1_q.pred_target : calc_link;

        s2_d                  = '0;
        s2_d.flags.taken      = calc_taken;
        s2_d.flags.ex_valid   = ex_hit;
        s2_d.flags.mispredict = (actual_pc != pred_pc) && !ex_hit;
        s2_d.target           = calc_target;
        s2_d.link             = calc_link;
        s2_d.redirect         = actual_pc;
        s2_d.tag              = s1_q.tag;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else if (flush_i) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s2_adv) s2_v <= s1_v;
            if (s1_adv) s1_v <= accept;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (accept)          s1_q <= s1_d;
            if (s2_adv && s1_v)  s2_q <= s2_d;
        end
    end

    // Saturating statistics, untouched by flush.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else if (out_xfer) begin
            if (branch_cnt_o != '1)
                branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            if (s2_q.flags.mispredict && (mispredict_cnt_o != '1))
                mispredict_cnt_o <= mispredict_cnt_o + CNT_W'(1);
        end
    end

    assign valid_o       = s2_v;
    assign taken_o       = s2_q.flags.taken;
    assign target_o      = s2_q.target;
    assign link_o        = s2_q.link;
    assign mispredict_o  = s2_q.flags.mispredict;
    assign redirect_pc_o = s2_q.redirect;
    assign ex_valid_o    = s2_q.flags.ex_valid;
    assign ex_origin_o   = s2_q.target;
    assign tag_o         = s2_q.tag;

endmodule

// File: tb/tb_branch_exec_pipe.sv
// Scoreboard bench for branch_exec_pipe: two builds (RVC off/on, 4-bit
// counters) share one stimulus stream and are checked against a reference model.
module tb_branch_exec_pipe;
    import drac_pkg::*;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned TAG_W = 6;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic              flush = 1'b0, valid = 1'b0, rdy = 1'b1;
    branch_op_t        op = BR_EQ;
    logic [XLEN-1:0]   pc = '0, imm = '0, rs1 = '0, rs2 = '0, ptgt = '0;
    logic              is_rvc = 1'b0, ptk = 1'b0;
    logic [TAG_W-1:0]  tag = '0;

    logic              ready0, v0, taken0, misp0, exv0;
    logic [XLEN-1:0]   target0, link0, redir0, exo0;
    logic [TAG_W-1:0]  tag0;
    logic [CNT_W-1:0]  bc0, mc0;
    logic              ready1, v1, taken1, misp1, exv1;
    logic [XLEN-1:0]   target1, link1, redir1, exo1;
    logic [TAG_W-1:0]  tag1;
    logic [CNT_W-1:0]  bc1, mc1;

    branch_exec_pipe #(.XLEN(XLEN), .RVC_EN(0), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_dut0 (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .valid_i(valid), .ready_o(ready0),
        .op_i(op), .pc_i(pc), .imm_i(imm), .rs1_i(rs1), .rs2_i(rs2), .is_rvc_i(is_rvc),
        .pred_taken_i(ptk), .pred_target_i(ptgt), .tag_i(tag), .valid_o(v0), .ready_i(rdy),
        .taken_o(taken0), .target_o(target0), .link_o(link0), .mispredict_o(misp0),
        .redirect_pc_o(redir0), .ex_valid_o(exv0), .ex_origin_o(exo0), .tag_o(tag0),
        .branch_cnt_o(bc0), .mispredict_cnt_o(mc0));

    branch_exec_pipe #(.XLEN(XLEN), .RVC_EN(1), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_dut1 (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .valid_i(valid), .ready_o(ready1),
        .op_i(op), .pc_i(pc), .imm_i(imm), .rs1_i(rs1), .rs2_i(rs2), .is_rvc_i(is_rvc),
        .pred_taken_i(ptk), .pred_target_i(ptgt), .tag_i(tag), .valid_o(v1), .ready_i(rdy),
        .taken_o(taken1), .target_o(target1), .link_o(link1), .mispredict_o(misp1),
        .redirect_pc_o(redir1), .ex_valid_o(exv1), .ex_origin_o(exo1), .tag_o(tag1),
        .branch_cnt_o(bc1), .mispredict_cnt_o(mc1));

    typedef struct {
        logic             taken;
        logic [XLEN-1:0]  target;
        logic [XLEN-1:0]  link;
        logic             misp;
        logic [XLEN-1:0]  redirect;
        logic             exv;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        exp_t e0;
        exp_t e1;
        int   acc;
    } entry_t;

    entry_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit rand_rdy = 1'b0;
    logic [TAG_W-1:0] next_tag = '0;
    int unsigned mbc0 = 0, mmc0 = 0, mbc1 = 0, mmc1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the architectural rules.
    function automatic exp_t model(input branch_op_t o, input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                                   input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit rv,
                                   input bit pt, input logic [XLEN-1:0] pt_tgt, input logic [TAG_W-1:0] tg,
                                   input bit rvc_en);
        exp_t e;
        longint sa = a;
        longint sb = b;
        logic [XLEN-1:0] pred;
        case (o)
            BR_EQ:   e.taken = (a == b);
            BR_NE:   e.taken = (a != b);
            BR_LT:   e.taken = (sa < sb);
            BR_GE:   e.taken = !(sa < sb);
            BR_LTU:  e.taken = (a < b);
            BR_GEU:  e.taken = !(a < b);
            default: e.taken = 1'b1;
        endcase
        if (o == BR_JAL)       e.target = (p + im) & ~64'd1;
        else if (o == BR_JALR) e.target = (a + im) & ~64'd1;
        else                   e.target = p + im;
        e.link     = p + ((rvc_en && rv) ? 64'd2 : 64'd4);
        e.exv      = e.taken && (rvc_en ? e.target[0] : e.target[1]);
        e.redirect = e.taken ? e.target : e.link;
        pred       = pt ? pt_tgt : e.link;
        e.misp     = (e.redirect != pred) && !e.exv;
        e.tag      = tg;
        return e;
    endfunction

    task automatic cmp_entry(input string s, input exp_t e, input logic tk, input logic [XLEN-1:0] tg,
                             input logic [XLEN-1:0] lk, input logic mp, input logic [XLEN-1:0] rd,
                             input logic ev, input logic [XLEN-1:0] eo, input logic [TAG_W-1:0] tt);
        chk({"taken", s}, tk, e.taken);
        chk({"target", s}, tg, e.target);
        chk({"link", s}, lk, e.link);
        chk({"mispredict", s}, mp, e.misp);
        chk({"redirect", s}, rd, e.redirect);
        chk({"ex_valid", s}, ev, e.exv);
        if (e.exv) chk({"ex_origin", s}, eo, e.target);
        chk({"tag", s}, tt, e.tag);
    endtask

    logic exp_v;
    // Monitor: every cycle check handshake/counters; pop on an output transfer.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_v = (q.size() > 0) && (cyc >= q[0].acc + 1);
            chk("valid_o0", v0, exp_v);
            chk("valid_o1", v1, exp_v);
            chk("ready_o0", ready0, (q.size() < 2) || rdy);
            chk("ready_o1", ready1, (q.size() < 2) || rdy);
            chk("branch_cnt0", bc0, mbc0);
            chk("mispredict_cnt0", mc0, mmc0);
            chk("branch_cnt1", bc1, mbc1);
            chk("mispredict_cnt1", mc1, mmc1);
            if (exp_v) begin
                cmp_entry("0", q[0].e0, taken0, target0, link0, misp0, redir0, exv0, exo0, tag0);
                cmp_entry("1", q[0].e1, taken1, target1, link1, misp1, redir1, exv1, exo1, tag1);
                if (rdy) begin
                    if (mbc0 < CMAX) mbc0++;
                    if (mbc1 < CMAX) mbc1++;
                    if (q[0].e0.misp && mmc0 < CMAX) mmc0++;
                    if (q[0].e1.misp && mmc1 < CMAX) mmc1++;
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
    endtask

    // Present one entry until accepted; a flush entry is applied for one cycle only.
    task automatic send(input branch_op_t o, input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit rv,
                        input bit pt, input logic [XLEN-1:0] pt_tgt, input bit fl);
        entry_t en;
        op = o; pc = p; imm = im; rs1 = a; rs2 = b; is_rvc = rv; ptk = pt; ptgt = pt_tgt;
        tag = next_tag; valid = 1'b1; flush = fl;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            #2;
            if (fl) begin
                q.delete();
                next_tag++;
                tick();
                valid = 1'b0; flush = 1'b0;
                return;
            end
            if (ready0) begin
                en.e0  = model(o, p, im, a, b, rv, pt, pt_tgt, next_tag, 1'b0);
                en.e1  = model(o, p, im, a, b, rv, pt, pt_tgt, next_tag, 1'b1);
                en.acc = cyc + 1;
                q.push_back(en);
                next_tag++;
                tick();
                valid = 1'b0;
                return;
            end
            tick();
        end
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: got ready_o=0 for 60 cycles expected accept");
        valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        valid = 1'b0;
        for (int w = 0; w < 200; w++) begin
            if (q.size() == 0) return;
            tick();
        end
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: got %0d entries left expected 0", q.size());
        q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish by 300us");
        $fatal(1);
    end

    initial begin
        logic [XLEN-1:0] rp, ri, ra, rb, rt;
        branch_op_t      ro;
        bit              rpt;
        #2;
        chk("rst_valid0", v0, 1'b0);
        chk("rst_valid1", v1, 1'b0);
        chk("rst_tag0", tag0, '0);
        chk("rst_target0", target0, '0);
        chk("rst_redirect1", redir1, '0);
        chk("rst_bcnt0", bc0, '0);
        chk("rst_mcnt1", mc1, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        mon_en = 1'b1;
        tick();

        // Directed cases
        send(BR_EQ,   64'h1000, 64'h20, 64'd5, 64'd5, 1'b0, 1'b1, 64'h1020, 1'b0);
        send(BR_LT,   64'h1000, 64'h40, '1, 64'd1, 1'b0, 1'b0, 64'h0, 1'b0);
        send(BR_LTU,  64'h1000, 64'h40, '1, 64'd1, 1'b0, 1'b0, 64'h0, 1'b0);
        send(BR_JALR, 64'h3000, 64'h2, 64'h2001, 64'h0, 1'b0, 1'b1, 64'h2002, 1'b0);
        send(BR_EQ,   64'h1000, 64'h8, 64'd1, 64'd2, 1'b1, 1'b0, 64'h0, 1'b0);
        send(BR_NE,   64'h1000, 64'h11, 64'd1, 64'd2, 1'b1, 1'b0, 64'h0, 1'b0);
        send(BR_JAL,  64'h1002, 64'h7, 64'd0, 64'd0, 1'b1, 1'b1, 64'h1008, 1'b0);
        send(BR_GE,   64'h8000, -64'sd16, 64'd1, '1, 1'b0, 1'b1, 64'h7ff0, 1'b0);
        send(BR_GEU,  64'h8000, 64'h100, 64'd1, '1, 1'b0, 1'b1, 64'h8100, 1'b0);
        drain();
        idle(2);

        // Stream of six with a three-cycle stall in the middle
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                rdy = 1'b0;
                fork
                    begin repeat (3) @(posedge clk); #1 rdy = 1'b1; end
                join_none
            end
            send(BR_NE, 64'h5000 + 64'(i * 4), 64'h40, 64'(i), 64'd2, 1'b0, 1'b1, 64'h5040, 1'b0);
        end
        drain();
        idle(2);

        // Flush with both stages full and the consumer ready
        rdy = 1'b0;
        send(BR_EQ, 64'h6000, 64'h10, 64'd3, 64'd3, 1'b0, 1'b0, 64'h0, 1'b0);
        send(BR_EQ, 64'h6004, 64'h10, 64'd3, 64'd4, 1'b0, 1'b0, 64'h0, 1'b0);
        rdy = 1'b1;
        send(BR_JAL, 64'h6008, 64'h40, 64'd0, 64'd0, 1'b0, 1'b0, 64'h0, 1'b1);
        idle(2);
        send(BR_EQ, 64'h6100, 64'h20, 64'd9, 64'd9, 1'b0, 1'b1, 64'h6120, 1'b0);
        drain();

        // Counter saturation with 20 mispredicting branches
        for (int i = 0; i < 20; i++)
            send(BR_EQ, 64'h4000, 64'h100, 64'd7, 64'd7, 1'b0, 1'b0, 64'h0, 1'b0);
        drain();
        idle(2);

        // Randomized traffic with random backpressure and occasional flushes
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ro  = branch_op_t'($urandom_range(0, 7));
            rp  = {$urandom(), $urandom()} & ~64'd1;
            ri  = ($urandom_range(0, 1) != 0) ? 64'($signed(12'($urandom()))) : {$urandom(), $urandom()};
            ra  = {$urandom(), $urandom()};
            rb  = ($urandom_range(0, 3) == 0) ? ra : {$urandom(), $urandom()};
            rpt = ($urandom_range(0, 1) != 0);
            rt  = ($urandom_range(0, 1) != 0) ? rp + ri : {$urandom(), $urandom()};
            send(ro, rp, ri, ra, rb, ($urandom_range(0, 1) != 0), rpt, rt,
                 ($urandom_range(0, 24) == 0));
            if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy = 1'b0;
        rdy = 1'b1;
        drain();
        idle(3);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
